// File: rtl/mole_sched_pkg.sv
// Shared types and constants for the whac-a-mole mole scheduler.
package mole_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

  localparam logic [15:0] LFSR_TAPS       = 16'hB400;
  localparam int          DEF_WIN_L1_MS   = 2000;
  localparam int          DEF_WIN_L2_MS   = 1200;
  localparam int          DEF_WIN_L3_MS   = 700;
  localparam int          DEF_WIN_MIN_MS  = 300;

  // Level 0 never reaches level_q, so it shares the level-1 window.
  function automatic logic [11:0] level_to_win_ms(input logic [1:0] lvl,
                                                  input int w1, input int w2, input int w3);
    case (lvl)
      2'd2:    return 12'(w2);
      2'd3:    return 12'(w3);
      default: return 12'(w1);
    endcase
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR; reloads SEED on reset only.
module mole_lfsr
  import mole_sched_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Picks pseudo-random mole positions and times the level-dependent hit window.
// Optional window speedup is compiled in with `define MOLE_SPEEDUP_EN.
module mole_scheduler
  import mole_sched_pkg::*;
#(
  parameter int          CLK_HZ          = 50000000,
  parameter int          NUM_MOLES       = 18,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          WIN_L1_MS       = DEF_WIN_L1_MS,
  parameter int          WIN_L2_MS       = DEF_WIN_L2_MS,
  parameter int          WIN_L3_MS       = DEF_WIN_L3_MS,
  parameter int          WIN_MIN_MS      = DEF_WIN_MIN_MS,
  parameter int          SPEEDUP_STEP_MS = 50,
  parameter int          SPEEDUP_EVERY   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [1:0]           level,
  input  logic                 mole_req,
  input  logic                 timer_start,
  output logic [NUM_MOLES-1:0] led_number,
  output logic                 time_left,
  output logic [4:0]           mole_idx,
  output logic [15:0]          mole_count,
  output logic [11:0]          win_ms
);

  localparam int TICKS_PER_MS = CLK_HZ / 1000;
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  if (TICKS_PER_MS < 1 || NUM_MOLES < 2 || NUM_MOLES > 32 || LFSR_SEED == 16'h0 ||
      WIN_L1_MS == 0 || WIN_L2_MS == 0 || WIN_L3_MS == 0 || WIN_MIN_MS == 0 ||
      SPEEDUP_EVERY == 0 || SPEEDUP_STEP_MS >= 4096) begin : g_bad_cfg
    $error("mole_scheduler: invalid parameter configuration");
  end

  logic [15:0] lfsr;
  logic        lfsr_unused;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .lfsr    (lfsr)
  );
  assign lfsr_unused = ^lfsr[15:5];

  state_e               state_q, state_d;
  logic [1:0]           level_q, level_d;
  logic [4:0]           mole_idx_q, mole_idx_d;
  logic [15:0]          mole_count_q, mole_count_d;
  logic [11:0]          win_ms_q, win_ms_d;
  logic [11:0]          ms_left_q, ms_left_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [NUM_MOLES-1:0] led_q, led_d;
  logic                 time_left_q, time_left_d;
  logic [5:0]           pick_c;
  logic [4:0]           pick_idx;

  // Fold the 5-bit LFSR slice into range, then step past a repeat of the last mole.
  always_comb begin
    pick_c = {1'b0, lfsr[4:0]};
    if (pick_c >= 6'(NUM_MOLES)) pick_c = pick_c - 6'(NUM_MOLES);
    if (pick_c[4:0] == mole_idx_q && mole_count_q != 16'd0)
      pick_c = (pick_c + 6'd1 == 6'(NUM_MOLES)) ? 6'd0 : pick_c + 6'd1;
    pick_idx = pick_c[4:0];
  end

  always_comb begin
    state_d      = state_q;
    level_d      = (level != 2'd0) ? level : level_q;
    mole_idx_d   = mole_idx_q;
    mole_count_d = mole_count_q;
    win_ms_d     = win_ms_q;
    ms_left_d    = ms_left_q;
    presc_d      = presc_q;
    if (clear) begin
      state_d      = IDLE;
      level_d      = level_q;
      mole_idx_d   = 5'd0;
      mole_count_d = 16'd0;
      win_ms_d     = level_to_win_ms(level_q, WIN_L1_MS, WIN_L2_MS, WIN_L3_MS);
    end else begin
      if (level_d != level_q)
        win_ms_d = level_to_win_ms(level_d, WIN_L1_MS, WIN_L2_MS, WIN_L3_MS);
      if (mole_req) begin
        state_d      = RUN;
        mole_idx_d   = pick_idx;
        ms_left_d    = win_ms_q;
        presc_d      = '0;
        mole_count_d = (mole_count_q == 16'hFFFF) ? mole_count_q : mole_count_q + 16'd1;
`ifdef MOLE_SPEEDUP_EN
        // A level change in the same cycle keeps the fresh base window.
        if (level_d == level_q && (mole_count_d % 16'(SPEEDUP_EVERY)) == 16'd0) begin
          if ({1'b0, win_ms_q} >= 13'(WIN_MIN_MS) + 13'(SPEEDUP_STEP_MS))
            win_ms_d = win_ms_q - 12'(SPEEDUP_STEP_MS);
          else
            win_ms_d = 12'(WIN_MIN_MS);
        end
`endif
      end else if (state_q == RUN && timer_start) begin
        if (presc_q == PW'(TICKS_PER_MS - 1)) begin
          presc_d   = '0;
          ms_left_d = ms_left_q - 12'd1;
          if (ms_left_q == 12'd1) state_d = EXPIRED;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
    led_d       = (state_d == RUN) ? (NUM_MOLES'(1) << mole_idx_d) : '0;
    time_left_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      level_q      <= 2'd1;
      mole_idx_q   <= 5'd0;
      mole_count_q <= 16'd0;
      win_ms_q     <= 12'(WIN_L1_MS);
      ms_left_q    <= 12'd0;
      presc_q      <= '0;
      led_q        <= '0;
      time_left_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      mole_idx_q   <= mole_idx_d;
      mole_count_q <= mole_count_d;
      win_ms_q     <= win_ms_d;
      ms_left_q    <= ms_left_d;
      presc_q      <= presc_d;
      led_q        <= led_d;
      time_left_q  <= time_left_d;
    end
  end

  assign led_number = led_q;
  assign time_left  = time_left_q;
  assign mole_idx   = mole_idx_q;
  assign mole_count = mole_count_q;
  assign win_ms     = win_ms_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Table-driven bench for mole_scheduler at 4 ticks/ms with 3/2/1 ms level windows.
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  level = 2'd1;
  logic        mole_req = 1'b0;
  logic        timer_start = 1'b0;
  logic [17:0] led_number;
  logic        time_left;
  logic [4:0]  mole_idx;
  logic [15:0] mole_count;
  logic [11:0] win_ms;

  int errors = 0;
  int checks = 0;

  mole_scheduler #(
    .CLK_HZ(4000), .NUM_MOLES(18), .LFSR_SEED(16'hACE1),
    .WIN_L1_MS(3), .WIN_L2_MS(2), .WIN_L3_MS(1), .WIN_MIN_MS(1),
    .SPEEDUP_STEP_MS(1), .SPEEDUP_EVERY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .level(level),
    .mole_req(mole_req), .timer_start(timer_start),
    .led_number(led_number), .time_left(time_left), .mole_idx(mole_idx),
    .mole_count(mole_count), .win_ms(win_ms)
  );

  always #5 clk = ~clk;

  // Reference for the pseudo-random pick: LFSR sequence plus the no-repeat rule.
  logic [15:0] m_lfsr;
  logic [4:0]  m_idx;
  logic [15:0] m_cnt;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [4:0] pick(input logic [15:0] x, input logic [4:0] prev,
                                      input logic [15:0] cnt);
    int c;
    c = int'(x[4:0]);
    if (c >= 18) c = c - 18;
    if (c == int'(prev) && cnt != 16'd0) c = (c + 1) % 18;
    return 5'(c);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_lfsr <= 16'hACE1;
      m_idx  <= 5'd0;
      m_cnt  <= 16'd0;
    end else begin
      m_lfsr <= lfsr_next(m_lfsr);
      if (clear) begin
        m_idx <= 5'd0;
        m_cnt <= 16'd0;
      end else if (mole_req) begin
        m_idx <= pick(m_lfsr, m_idx, m_cnt);
        m_cnt <= m_cnt + 16'd1;
      end
    end
  end

  typedef struct {
    logic        rn, clr;
    logic [1:0]  lvl;
    logic        req, ts;
    logic        e_tl;
    logic [15:0] e_cnt;
    logic [11:0] e_win;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rn, input logic clr, input logic [1:0] lvl,
                              input logic req, input logic ts, input logic e_tl,
                              input logic [15:0] e_cnt, input logic [11:0] e_win);
    vec_t v;
    v.rn = rn; v.clr = clr; v.lvl = lvl; v.req = req; v.ts = ts;
    v.e_tl = e_tl; v.e_cnt = e_cnt; v.e_win = e_win;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] one18 = 18'd1;
  logic [17:0] exp_led;
  logic [4:0]  prev_idx;
  logic        ok;
  int          sp_exp[7];

  initial begin
    // 12-cycle window at level 1
    add(0,0,1,0,0, 0,0,3);
    add(1,0,0,0,0, 0,0,3);
    add(1,0,0,1,1, 1,1,3);
    for (int i = 0; i < 11; i++) add(1,0,0,0,1, 1,1,3);
    add(1,0,0,0,1, 0,1,3);
    add(1,0,0,0,1, 0,1,3);
    // 17 high cycles with a 5-cycle pause
    add(1,1,0,0,0, 0,0,3);
    add(1,0,0,1,1, 1,1,3);
    for (int i = 0; i < 3; i++) add(1,0,0,0,1, 1,1,3);
    for (int i = 0; i < 5; i++) add(1,0,0,0,0, 1,1,3);
    for (int i = 0; i < 8; i++) add(1,0,0,0,1, 1,1,3);
    add(1,0,0,0,1, 0,1,3);
    // level 3 latched, then level 0 keeps it; request on the expiry edge
    add(1,1,0,0,0, 0,0,3);
    add(1,0,3,0,0, 0,0,1);
    add(1,0,0,0,0, 0,0,1);
    add(1,0,0,1,1, 1,1,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,1, 1,1,1);
    add(1,0,0,1,1, 1,2,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,1, 1,2,1);
    add(1,0,0,0,1, 0,2,1);
    // level 2, clear beats request, reset during RUN
    add(1,0,2,0,0, 0,2,2);
    add(1,0,0,1,1, 1,3,2);
    add(1,1,0,1,1, 0,0,2);
    add(1,0,0,1,1, 1,1,2);
    add(0,0,0,0,1, 0,0,3);
    add(1,0,0,0,0, 0,0,3);

    foreach (vq[i]) begin
      reset_n = vq[i].rn; clear = vq[i].clr; level = vq[i].lvl;
      mole_req = vq[i].req; timer_start = vq[i].ts;
      step();
      exp_led = vq[i].e_tl ? (one18 << m_idx) : 18'd0;
      chk($sformatf("row%0d time_left", i), 32'(time_left), 32'(vq[i].e_tl));
      chk($sformatf("row%0d led_number", i), 32'(led_number), 32'(exp_led));
      chk($sformatf("row%0d mole_idx", i), 32'(mole_idx), 32'(m_idx));
      chk($sformatf("row%0d mole_count", i), 32'(mole_count), 32'(vq[i].e_cnt));
      chk($sformatf("row%0d win_ms", i), 32'(win_ms), 32'(vq[i].e_win));
    end

    // 200 back-to-back requests
    reset_n = 1'b1; level = 2'd0; timer_start = 1'b0;
    clear = 1'b1; mole_req = 1'b0;
    step();
    clear = 1'b0; mole_req = 1'b1;
    prev_idx = 5'd31;
    for (int i = 0; i < 200; i++) begin
      step();
      ok = $onehot(led_number) && (mole_idx < 5'd18) && (mole_idx != prev_idx) &&
           (led_number == (one18 << mole_idx)) && time_left;
      chk($sformatf("b2b%0d rules", i), 32'(ok), 32'd1);
      chk($sformatf("b2b%0d mole_idx", i), 32'(mole_idx), 32'(m_idx));
      prev_idx = mole_idx;
    end
    mole_req = 1'b0;
    chk("b2b mole_count", 32'(mole_count), 32'd200);

    // window progression across seven moles at level 1
`ifdef MOLE_SPEEDUP_EN
    sp_exp = '{3, 3, 2, 2, 1, 1, 1};
`else
    sp_exp = '{3, 3, 3, 3, 3, 3, 3};
`endif
    reset_n = 1'b0; level = 2'd1;
    step();
    reset_n = 1'b1; level = 2'd0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("speed mole%0d win_ms", k + 1), 32'(win_ms), 32'(sp_exp[k]));
      mole_req = 1'b1;
      step();
      mole_req = 1'b0;
      step();
    end
    chk("speed mole_count", 32'(mole_count), 32'd7);
    level = 2'd2;
    step();
    chk("speed level2 win_ms", 32'(win_ms), 32'd2);
    level = 2'd1;
    step();
    level = 2'd0;
    chk("speed level1 restore", 32'(win_ms), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
